// File: rtl/prog_seq_if.sv
// Command/status bundle for prog_seq: the master drives PC commands; the slave returns PC and stack status.
// No handshake: one command word per cycle, sampled on the rising edge.
interface prog_seq_if #(
    parameter int AW    = 8,
    parameter int JW    = 5,
    parameter int OW    = 4,
    parameter int DEPTH = 4
);
    logic                    Load_PC;
    logic                    Call_PC;
    logic                    Ret_PC;
    logic                    Br_PC;
    logic                    Inc_PC;
    logic [JW-1:0]           addr;
    logic [OW-1:0]           ofs;
    logic                    clr_err;
    logic [AW-1:0]           insaddr;
    logic [$clog2(DEPTH):0]  stk_lvl;
    logic                    stk_full;
    logic                    stk_empty;
    logic                    err;

    modport master (
        output Load_PC, Call_PC, Ret_PC, Br_PC, Inc_PC, addr, ofs, clr_err,
        input  insaddr, stk_lvl, stk_full, stk_empty, err
    );

    modport slave (
        input  Load_PC, Call_PC, Ret_PC, Br_PC, Inc_PC, addr, ofs, clr_err,
        output insaddr, stk_lvl, stk_full, stk_empty, err
    );
endinterface

// File: rtl/prog_seq.sv
// Program sequencer: PC with load/call/return/branch/increment and a circular return stack; 1-cycle command-to-insaddr latency, no backpressure.
// Define PROG_SEQ_TRAP_EN to trap stack overflow/underflow to TRAP_VEC with sticky err; otherwise overflow overwrites the oldest entry.
module prog_seq #(
    parameter int            AW       = 8,
    parameter int            JW       = 5,
    parameter int            OW       = 4,
    parameter int            DEPTH    = 4,
    parameter logic [AW-1:0] TRAP_VEC = '0
) (
    input  logic       clk,
    input  logic       reset,
    prog_seq_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

`ifdef PROG_SEQ_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic [AW-1:0] r_pc;
    logic [LW-1:0] r_lvl;
    logic [PW-1:0] r_top;
    logic          r_err;
    logic [AW-1:0] r_stk [DEPTH];

    logic [AW-1:0] w_pc_nxt;
    logic [LW-1:0] w_lvl_nxt;
    logic [PW-1:0] w_top_nxt;
    logic          w_err_nxt;
    logic          w_push;
    logic          w_full;
    logic          w_empty;
    logic [AW-1:0] w_pc_inc;
    logic [AW-1:0] w_addr_ext;
    logic [AW-1:0] w_ofs_ext;
    logic [PW-1:0] w_pop_idx;

    assign w_full     = (r_lvl == LW'(DEPTH));
    assign w_empty    = (r_lvl == '0);
    assign w_pc_inc   = r_pc + AW'(1);
    assign w_addr_ext = AW'(bus.addr);
    assign w_ofs_ext  = AW'($signed(bus.ofs));
    // r_top is the next free slot, so the newest entry sits one below it
    assign w_pop_idx  = r_top - PW'(1);

    always_comb begin
        w_pc_nxt  = r_pc;
        w_lvl_nxt = r_lvl;
        w_top_nxt = r_top;
        w_push    = 1'b0;
        w_err_nxt = bus.clr_err ? 1'b0 : r_err;
        if (bus.Load_PC) begin
            w_pc_nxt = w_addr_ext;
        end else if (bus.Call_PC) begin
            if (w_full && TRAP_EN) begin
                w_pc_nxt  = TRAP_VEC;
                w_err_nxt = 1'b1;
            end else begin
                // When full, the free slot is the oldest entry: overwrite it, level stays put
                w_push    = 1'b1;
                w_pc_nxt  = w_addr_ext;
                w_top_nxt = r_top + PW'(1);
                if (!w_full) begin
                    w_lvl_nxt = r_lvl + LW'(1);
                end
            end
        end else if (bus.Ret_PC) begin
            if (!w_empty) begin
                w_pc_nxt  = r_stk[w_pop_idx];
                w_top_nxt = w_pop_idx;
                w_lvl_nxt = r_lvl - LW'(1);
            end else if (TRAP_EN) begin
                w_pc_nxt  = TRAP_VEC;
                w_err_nxt = 1'b1;
            end
        end else if (bus.Br_PC) begin
            w_pc_nxt = r_pc + w_ofs_ext;
        end else if (bus.Inc_PC) begin
            w_pc_nxt = w_pc_inc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc  <= '0;
            r_lvl <= '0;
            r_top <= '0;
            r_err <= 1'b0;
        end else begin
            r_pc  <= w_pc_nxt;
            r_lvl <= w_lvl_nxt;
            r_top <= w_top_nxt;
            r_err <= w_err_nxt;
        end
    end

    // Stack storage carries no reset; entries above the level are never read
    always_ff @(posedge clk) begin
        if (reset && w_push) begin
            r_stk[r_top] <= w_pc_inc;
        end
    end

    assign bus.insaddr   = r_pc;
    assign bus.stk_lvl   = r_lvl;
    assign bus.stk_full  = w_full;
    assign bus.stk_empty = w_empty;
    assign bus.err       = TRAP_EN ? r_err : 1'b0;
endmodule

// File: tb/tb_prog_seq.sv
// Directed bench for prog_seq: vector table for single-cycle commands, hand sequences for stack depth, traps and reset.
module tb_prog_seq;
    localparam logic [4:0] NO = 5'b00000;
    localparam logic [4:0] LD = 5'b10000;
    localparam logic [4:0] CL = 5'b01000;
    localparam logic [4:0] RT = 5'b00100;
    localparam logic [4:0] BR = 5'b00010;
    localparam logic [4:0] IN = 5'b00001;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    prog_seq_if #(.AW(8), .JW(5), .OW(4), .DEPTH(4)) u_if ();

    prog_seq #(.AW(8), .JW(5), .OW(4), .DEPTH(4), .TRAP_VEC(8'h00)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    typedef struct {
        string      name;
        logic [4:0] cmd;
        logic [4:0] addr;
        logic [3:0] ofs;
        logic [7:0] pc;
        logic [2:0] lvl;
    } vec_t;

    vec_t vq[$];

    task automatic addv(input string n, input logic [4:0] c, input logic [4:0] a,
                        input logic [3:0] o, input logic [7:0] pc, input logic [2:0] lvl);
        vec_t v;
        v.name = n; v.cmd = c; v.addr = a; v.ofs = o; v.pc = pc; v.lvl = lvl;
        vq.push_back(v);
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", n, act, exp);
        end
    endtask

    task automatic chk_state(input string n, input logic [7:0] pc, input logic [2:0] lvl, input logic e);
        chk({n, ".insaddr"}, 32'(u_if.insaddr), 32'(pc));
        chk({n, ".stk_lvl"}, 32'(u_if.stk_lvl), 32'(lvl));
        chk({n, ".stk_empty"}, 32'(u_if.stk_empty), 32'(lvl == 3'd0));
        chk({n, ".stk_full"}, 32'(u_if.stk_full), 32'(lvl == 3'd4));
        chk({n, ".err"}, 32'(u_if.err), 32'(e));
    endtask

    task automatic drive(input logic [4:0] c, input logic [4:0] a, input logic [3:0] o, input logic clr);
        u_if.Load_PC = c[4];
        u_if.Call_PC = c[3];
        u_if.Ret_PC  = c[2];
        u_if.Br_PC   = c[1];
        u_if.Inc_PC  = c[0];
        u_if.addr    = a;
        u_if.ofs     = o;
        u_if.clr_err = clr;
    endtask

    task automatic step(input logic [4:0] c, input logic [4:0] a, input logic [3:0] o, input logic clr);
        drive(c, a, o, clr);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(NO, 5'h00, 4'h0, 1'b0);
        addv("inc0",       IN,           5'h00, 4'h0, 8'h01, 3'd0);
        addv("inc1",       IN,           5'h00, 4'h0, 8'h02, 3'd0);
        addv("inc2",       IN,           5'h00, 4'h0, 8'h03, 3'd0);
        addv("ld0",        LD,           5'h00, 4'h0, 8'h00, 3'd0);
        addv("br_m1",      BR,           5'h00, 4'hF, 8'hFF, 3'd0);
        addv("inc_wrap",   IN,           5'h00, 4'h0, 8'h00, 3'd0);
        addv("ld10",       LD,           5'h10, 4'h0, 8'h10, 3'd0);
        addv("br_m2",      BR,           5'h00, 4'hE, 8'h0E, 3'd0);
        addv("br_p7",      BR,           5'h00, 4'h7, 8'h15, 3'd0);
        addv("ld05",       LD,           5'h05, 4'h0, 8'h05, 3'd0);
        addv("call1a",     CL,           5'h1A, 4'h0, 8'h1A, 3'd1);
        addv("ret06",      RT,           5'h00, 4'h0, 8'h06, 3'd0);
        addv("ld_cl_in",   LD | CL | IN, 5'h03, 4'h0, 8'h03, 3'd0);
        addv("hold",       NO,           5'h1F, 4'h7, 8'h03, 3'd0);
`ifndef PROG_SEQ_TRAP_EN
        addv("ret_empty",  RT,           5'h00, 4'h0, 8'h03, 3'd0);
        addv("ret_br_emp", RT | BR,      5'h00, 4'h7, 8'h03, 3'd0);
`endif
        addv("call_ret",   CL | RT,      5'h08, 4'h0, 8'h08, 3'd1);
        addv("ret_br_inc", RT | BR | IN, 5'h00, 4'h3, 8'h04, 3'd0);
        addv("br_over_in", BR | IN,      5'h00, 4'h8, 8'hFC, 3'd0);
        addv("call1f",     CL,           5'h1F, 4'h0, 8'h1F, 3'd1);
        addv("ld_over_rt", LD | RT,      5'h02, 4'h0, 8'h02, 3'd1);
        addv("ret_fd",     RT,           5'h00, 4'h0, 8'hFD, 3'd0);

        repeat (2) @(posedge clk);
        #1;
        chk_state("reset", 8'h00, 3'd0, 1'b0);
        reset = 1'b1;

        foreach (vq[i]) begin
            step(vq[i].cmd, vq[i].addr, vq[i].ofs, 1'b0);
            chk_state(vq[i].name, vq[i].pc, vq[i].lvl, 1'b0);
        end

        // Five nested calls into a four-deep stack
        step(LD, 5'h00, 4'h0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            step(CL, 5'(k), 4'h0, 1'b0);
            chk_state($sformatf("nest%0d", k), 8'(k), 3'(k), 1'b0);
        end
        step(CL, 5'h05, 4'h0, 1'b0);
`ifdef PROG_SEQ_TRAP_EN
        chk_state("call_full_trap", 8'h00, 3'd4, 1'b1);
        step(NO, 5'h00, 4'h0, 1'b1);
        chk_state("clr_err", 8'h00, 3'd4, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step(RT, 5'h00, 4'h0, 1'b0);
            chk_state($sformatf("unnest%0d", k), 8'(4 - k), 3'(3 - k), 1'b0);
        end
        step(RT, 5'h00, 4'h0, 1'b1);
        chk_state("ret_empty_trap_vs_clr", 8'h00, 3'd0, 1'b1);
        step(NO, 5'h00, 4'h0, 1'b1);
        chk_state("clr_err2", 8'h00, 3'd0, 1'b0);
`else
        chk_state("call_full_wrap", 8'h05, 3'd4, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step(RT, 5'h00, 4'h0, 1'b0);
            chk_state($sformatf("unnest%0d", k), 8'(5 - k), 3'(3 - k), 1'b0);
        end
        step(RT, 5'h00, 4'h0, 1'b0);
        chk_state("ret_empty_hold", 8'h02, 3'd0, 1'b0);
`endif

        // Asynchronous reset in the middle of a call sequence
        step(LD, 5'h00, 4'h0, 1'b0);
        step(CL, 5'h0A, 4'h0, 1'b0);
        chk_state("pre_rst_call", 8'h0A, 3'd1, 1'b0);
        drive(CL, 5'h0B, 4'h0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk_state("async_rst", 8'h00, 3'd0, 1'b0);
        @(posedge clk);
        #1;
        chk_state("rst_held_ignore", 8'h00, 3'd0, 1'b0);
        reset = 1'b1;
        step(IN, 5'h00, 4'h0, 1'b0);
        chk_state("first_after_rst", 8'h01, 3'd0, 1'b0);
`ifndef PROG_SEQ_TRAP_EN
        step(RT, 5'h00, 4'h0, 1'b0);
        chk_state("stack_gone", 8'h01, 3'd0, 1'b0);
`endif
        drive(NO, 5'h00, 4'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
